// File: rtl/ifm_sort_ctrl.sv
// RX frame sorter: copies good frames to the good FIFO followed by a status record, drains bad frames.
// Optional frame counters are built only when IFM_SORT_CNT_EN is defined.
module ifm_sort_ctrl #(
  parameter int          C_STS_WORDS = 6,
  parameter logic [31:0] C_STS_TAG   = 32'h5000_0000,
  parameter int          C_LEN_WORD  = 5
) (
  input  logic        s2mm_clk,
  input  logic        rx_reset,
  input  logic        info_fifo_empty,
  input  logic        info_fifo_rdata,
  output logic        info_fifo_rden,
  input  logic [72:0] data_fifo_rdata,
  output logic        data_fifo_rden,
  output logic [72:0] good_fifo_wdata,
  output logic        good_fifo_wren,
  input  logic        good_fifo_afull,
  output logic [36:0] ctrl_fifo_wdata,
  output logic        ctrl_fifo_wren,
  input  logic        ctrl_fifo_afull,
  output logic        busy,
  output logic [31:0] good_frame_cnt,
  output logic [31:0] drop_frame_cnt
);

  // state | meaning
  // IDLE  | waiting for a complete frame and enough downstream room
  // GOOD  | copying beats of a good frame into the good FIFO
  // DROP  | draining beats of a bad frame
  // STS   | writing the status record for the frame just copied
  typedef enum logic [1:0] {IDLE, GOOD, DROP, STS} state_t;

  localparam int IDX_W = (C_STS_WORDS > 1) ? $clog2(C_STS_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C_STS_WORDS - 1);
  localparam logic [IDX_W-1:0] LEN_IDX  = IDX_W'(C_LEN_WORD);

  state_t           state, state_nxt;
  logic [15:0]      byte_cnt, byte_cnt_nxt;
  logic [15:0]      len, len_nxt;
  logic [IDX_W-1:0] sts_idx, sts_idx_nxt;
  logic             beat_last;
  logic [3:0]       beat_bytes;
  logic [16:0]      byte_sum_w;
  logic [15:0]      byte_sum;
  logic [31:0]      sts_word;

  assign beat_last  = data_fifo_rdata[72];
  assign beat_bytes = 4'($countones(data_fifo_rdata[71:64]));
  assign byte_sum_w = {1'b0, byte_cnt} + {13'd0, beat_bytes};
  // Byte count saturates rather than wrapping on oversized frames.
  assign byte_sum   = byte_sum_w[16] ? 16'hFFFF : byte_sum_w[15:0];

  always_comb begin
    sts_word = 32'h0;
    if (sts_idx == '0)
      sts_word = C_STS_TAG;
    else if (sts_idx == LEN_IDX)
      sts_word = {16'h0, len};
  end

  always_ff @(posedge s2mm_clk) begin
    if (rx_reset) begin
      state    <= IDLE;
      byte_cnt <= '0;
      len      <= '0;
      sts_idx  <= '0;
    end else begin
      state    <= state_nxt;
      byte_cnt <= byte_cnt_nxt;
      len      <= len_nxt;
      sts_idx  <= sts_idx_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    byte_cnt_nxt    = byte_cnt;
    len_nxt         = len;
    sts_idx_nxt     = sts_idx;
    info_fifo_rden  = 1'b0;
    data_fifo_rden  = 1'b0;
    good_fifo_wren  = 1'b0;
    good_fifo_wdata = data_fifo_rdata;
    ctrl_fifo_wren  = 1'b0;
    ctrl_fifo_wdata = {(sts_idx == LAST_IDX), 4'hF, sts_word};
    case (state)
      IDLE: begin
        byte_cnt_nxt = '0;
        if (!info_fifo_empty) begin
          if (!info_fifo_rdata)
            state_nxt = DROP;
          // The whole status record must fit, so ctrl room is checked only here.
          else if (!good_fifo_afull && !ctrl_fifo_afull)
            state_nxt = GOOD;
        end
      end
      GOOD: begin
        if (!good_fifo_afull) begin
          data_fifo_rden = 1'b1;
          good_fifo_wren = 1'b1;
          byte_cnt_nxt   = byte_sum;
          if (beat_last) begin
            info_fifo_rden = 1'b1;
            len_nxt        = byte_sum;
            sts_idx_nxt    = '0;
            state_nxt      = STS;
          end
        end
      end
      DROP: begin
        data_fifo_rden = 1'b1;
        if (beat_last) begin
          info_fifo_rden = 1'b1;
          state_nxt      = IDLE;
        end
      end
      STS: begin
        ctrl_fifo_wren = 1'b1;
        sts_idx_nxt    = sts_idx + 1'b1;
        if (sts_idx == LAST_IDX) begin
          sts_idx_nxt = '0;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

`ifdef IFM_SORT_CNT_EN
  logic [31:0] good_cnt_q, drop_cnt_q;

  always_ff @(posedge s2mm_clk) begin
    if (rx_reset) begin
      good_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (state == GOOD && state_nxt == STS)
        good_cnt_q <= good_cnt_q + 32'd1;
      if (state == DROP && state_nxt == IDLE)
        drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  assign good_frame_cnt = good_cnt_q;
  assign drop_frame_cnt = drop_cnt_q;
`else
  assign good_frame_cnt = 32'h0;
  assign drop_frame_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_ifm_sort_ctrl.sv
// Scoreboard bench for ifm_sort_ctrl: FIFO models feed frames, a monitor checks good beats and status records.
module tb_ifm_sort_ctrl;
  localparam int          STS_WORDS = 6;
  localparam logic [31:0] STS_TAG   = 32'h5000_0000;
  localparam int          LEN_WORD  = 5;

  logic        s2mm_clk = 1'b0;
  logic        rx_reset = 1'b1;
  logic        info_fifo_empty;
  logic        info_fifo_rdata;
  logic        info_fifo_rden;
  logic [72:0] data_fifo_rdata;
  logic        data_fifo_rden;
  logic [72:0] good_fifo_wdata;
  logic        good_fifo_wren;
  logic        good_fifo_afull = 1'b0;
  logic [36:0] ctrl_fifo_wdata;
  logic        ctrl_fifo_wren;
  logic        ctrl_fifo_afull = 1'b0;
  logic        busy;
  logic [31:0] good_frame_cnt;
  logic [31:0] drop_frame_cnt;

  ifm_sort_ctrl dut (
    .s2mm_clk(s2mm_clk), .rx_reset(rx_reset),
    .info_fifo_empty(info_fifo_empty), .info_fifo_rdata(info_fifo_rdata), .info_fifo_rden(info_fifo_rden),
    .data_fifo_rdata(data_fifo_rdata), .data_fifo_rden(data_fifo_rden),
    .good_fifo_wdata(good_fifo_wdata), .good_fifo_wren(good_fifo_wren), .good_fifo_afull(good_fifo_afull),
    .ctrl_fifo_wdata(ctrl_fifo_wdata), .ctrl_fifo_wren(ctrl_fifo_wren), .ctrl_fifo_afull(ctrl_fifo_afull),
    .busy(busy), .good_frame_cnt(good_frame_cnt), .drop_frame_cnt(drop_frame_cnt)
  );

  always #5 s2mm_clk = ~s2mm_clk;

  logic [72:0] dq[$];
  bit          iq[$];
  logic [72:0] exp_good[$];
  logic [36:0] exp_ctrl[$];
  int          n_tests = 0, n_fail = 0;
  int          n_dpop = 0, n_gwr = 0, n_cwr = 0;
  logic [31:0] exp_gcnt = 0, exp_dcnt = 0;
  bit          pop_d = 0, pop_i = 0, end_prev = 0;
  logic [7:0]  ks[$];
  int          base_d, base_g, base_c, cyc;

  task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void upd_fifo();
    data_fifo_rdata = (dq.size() != 0) ? dq[0] : 73'h0;
    info_fifo_empty = (iq.size() == 0);
    info_fifo_rdata = (iq.size() != 0) ? iq[0] : 1'b0;
  endfunction

  // Show-ahead FIFO model: pops decided in the previous cycle take effect just after the edge.
  always @(posedge s2mm_clk) begin
    #1;
    if (pop_d && dq.size() != 0) void'(dq.pop_front());
    if (pop_i && iq.size() != 0) void'(iq.pop_front());
    pop_d = 0;
    pop_i = 0;
    upd_fifo();
  end

  always @(negedge s2mm_clk) begin
    pop_d = data_fifo_rden;
    pop_i = info_fifo_rden;
    if (data_fifo_rden) begin
      n_dpop++;
      check("data_pop_nonempty", dq.size() != 0, 1);
    end
    if (info_fifo_rden)
      check("info_pop_on_last", {data_fifo_rden, data_fifo_rdata[72], iq.size() != 0}, 3'b111);
    if (good_fifo_wren) begin
      n_gwr++;
      check("good_afull_respected", good_fifo_afull, 0);
      if (exp_good.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL good_unexpected: got %h expected none", good_fifo_wdata);
      end else
        check("good_beat", good_fifo_wdata, exp_good.pop_front());
    end
    if (ctrl_fifo_wren) begin
      n_cwr++;
      if (exp_ctrl.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL ctrl_unexpected: got %h expected none", ctrl_fifo_wdata);
      end else
        check("ctrl_word", ctrl_fifo_wdata, exp_ctrl.pop_front());
    end
    if (!rx_reset && end_prev)
      check("idle_gap", busy, 0);
    end_prev = !rx_reset && ((ctrl_fifo_wren && ctrl_fifo_wdata[36]) ||
                             (data_fifo_rden && info_fifo_rden && !good_fifo_wren));
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge s2mm_clk);
      #2;
    end
  endtask

  // Reference: a good frame yields its beats unchanged plus a record carrying the saturated byte total.
  task automatic push_frame(input bit good, input logic [7:0] keeps[$]);
    int          sum = 0;
    logic [15:0] len;
    logic [31:0] word;
    logic [72:0] beat;
    for (int i = 0; i < keeps.size(); i++) begin
      beat = {(i == keeps.size() - 1), keeps[i], $urandom(), $urandom()};
      dq.push_back(beat);
      if (good) exp_good.push_back(beat);
      sum += $countones(keeps[i]);
    end
    len = (sum > 65535) ? 16'hFFFF : 16'(sum);
    if (good) begin
      for (int w = 0; w < STS_WORDS; w++) begin
        word = (w == 0) ? STS_TAG : (w == LEN_WORD) ? {16'h0, len} : 32'h0;
        exp_ctrl.push_back({(w == STS_WORDS - 1), 4'hF, word});
      end
      exp_gcnt++;
    end else
      exp_dcnt++;
    iq.push_back(good);
    upd_fifo();
  endtask

  task automatic check_cnts(input string name);
`ifdef IFM_SORT_CNT_EN
    check({name, "_good_cnt"}, good_frame_cnt, exp_gcnt);
    check({name, "_drop_cnt"}, drop_frame_cnt, exp_dcnt);
`else
    check({name, "_good_cnt"}, good_frame_cnt, 0);
    check({name, "_drop_cnt"}, drop_frame_cnt, 0);
`endif
  endtask

  task automatic drain(input string name, input int budget);
    int c = 0;
    while ((dq.size() != 0 || iq.size() != 0 || exp_good.size() != 0 ||
            exp_ctrl.size() != 0 || busy) && c < budget) begin
      tick();
      c++;
    end
    check({name, "_drained"}, c < budget, 1);
    check_cnts(name);
  endtask

  initial begin
    upd_fifo();
    tick(3);
    check("rst_busy", busy, 0);
    check("rst_enables", {info_fifo_rden, data_fifo_rden, good_fifo_wren, ctrl_fifo_wren}, 0);
    check_cnts("rst");
    rx_reset = 1'b0;
    tick(2);

    // 3-beat good frame, 20 bytes
    base_g = n_gwr; base_c = n_cwr;
    ks = '{8'hFF, 8'hFF, 8'h0F};
    push_frame(1, ks);
    drain("good3", 100);
    check("good3_beats", n_gwr - base_g, 3);
    check("good3_words", n_cwr - base_c, 6);

    // 4-beat bad frame
    base_d = n_dpop; base_g = n_gwr; base_c = n_cwr;
    ks = '{8'hFF, 8'h3C, 8'h01, 8'h80};
    push_frame(0, ks);
    drain("bad4", 100);
    check("bad4_pops", n_dpop - base_d, 4);
    check("bad4_writes", (n_gwr - base_g) + (n_cwr - base_c), 0);

    // good FIFO backpressure after beat 2 of a 5-beat frame
    base_g = n_gwr;
    ks = '{8'hFF, 8'h0F, 8'hF0, 8'h01, 8'h07};
    push_frame(1, ks);
    cyc = 0;
    while (n_gwr < base_g + 2 && cyc < 50) begin tick(); cyc++; end
    check("afull_reach_beat2", cyc < 50, 1);
    good_fifo_afull = 1'b1;
    repeat (5) begin
      @(negedge s2mm_clk);
      check("afull_hold", {data_fifo_rden, good_fifo_wren, info_fifo_rden}, 0);
      @(posedge s2mm_clk); #2;
    end
    good_fifo_afull = 1'b0;
    @(negedge s2mm_clk);
    check("afull_resume", good_fifo_wren, 1);
    @(posedge s2mm_clk); #2;
    drain("afull5", 100);

    // ctrl FIFO room gates a good frame start but not a drop
    ctrl_fifo_afull = 1'b1;
    base_d = n_dpop;
    ks = '{8'hFF, 8'h03};
    push_frame(1, ks);
    tick(5);
    check("caf_no_pop", n_dpop - base_d, 0);
    check("caf_idle", busy, 0);
    ctrl_fifo_afull = 1'b0;
    @(negedge s2mm_clk);
    check("caf_release_cycle", {busy, data_fifo_rden}, 0);
    @(posedge s2mm_clk); #2;
    @(negedge s2mm_clk);
    check("caf_first_pop", data_fifo_rden, 1);
    @(posedge s2mm_clk); #2;
    drain("caf_good", 100);
    ctrl_fifo_afull = 1'b1;
    base_d = n_dpop;
    ks = '{8'h11, 8'h22, 8'h44};
    push_frame(0, ks);
    drain("caf_bad", 100);
    check("caf_bad_pops", n_dpop - base_d, 3);
    ctrl_fifo_afull = 1'b0;

    // back-to-back single-beat frames good/bad/good
    base_g = n_gwr; base_c = n_cwr;
    ks = '{8'h01};
    push_frame(1, ks);
    push_frame(0, ks);
    push_frame(1, ks);
    drain("b2b", 100);
    check("b2b_beats", n_gwr - base_g, 2);
    check("b2b_words", n_cwr - base_c, 12);

    // reset while copying beat 2 of a good frame
    base_g = n_gwr;
    ks = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    push_frame(1, ks);
    cyc = 0;
    while (n_gwr < base_g + 1 && cyc < 50) begin tick(); cyc++; end
    check("rst_reach_beat2", cyc < 50, 1);
    rx_reset = 1'b1;
    tick();
    @(negedge s2mm_clk);
    check("midrst_enables", {info_fifo_rden, data_fifo_rden, good_fifo_wren, ctrl_fifo_wren}, 0);
    check("midrst_busy", busy, 0);
    dq.delete(); iq.delete(); exp_good.delete(); exp_ctrl.delete();
    exp_gcnt = 0; exp_dcnt = 0;
    upd_fifo();
    check_cnts("midrst");
    @(posedge s2mm_clk); #2;
    rx_reset = 1'b0;
    tick(3);
    @(negedge s2mm_clk);
    check("postrst_wait", {busy, data_fifo_rden}, 0);
    @(posedge s2mm_clk); #2;
    ks = '{8'h0F, 8'hFF};
    push_frame(1, ks);
    drain("postrst", 100);

    // randomized frames under random backpressure
    for (int f = 0; f < 40; f++) begin
      ks.delete();
      for (int b = 0; b < $urandom_range(1, 6); b++) ks.push_back(8'($urandom()));
      push_frame($urandom_range(0, 1) == 1, ks);
    end
    cyc = 0;
    while ((iq.size() != 0 || busy) && cyc < 3000) begin
      good_fifo_afull = ($urandom_range(0, 3) == 0);
      ctrl_fifo_afull = ($urandom_range(0, 3) == 0);
      tick();
      cyc++;
    end
    good_fifo_afull = 1'b0;
    ctrl_fifo_afull = 1'b0;
    drain("random", 500);

    // oversized frame saturates the length field
    ks.delete();
    for (int b = 0; b < 8200; b++) ks.push_back(8'hFF);
    push_frame(1, ks);
    drain("saturate", 9000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
